// File: rtl/mem_access_unit_if.sv
// =============================================================================
// mem_access_unit_if : pipeline request/response and data-memory bus bundle
// Rev 1.0
// =============================================================================
`default_nettype none

interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmtype;
  logic        stall;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dmtype, mem_ack, mem_rdata,
    output stall, resp_valid, resp_err, rdata_out,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dmtype, mem_ack, mem_rdata,
    input  stall, resp_valid, resp_err, rdata_out,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// =============================================================================
// mem_access_unit : MEM-stage load/store sequencer with lane steering and timeout
// Rev 1.0
// =============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] c_DM_WORD  = 3'b000;
  localparam logic [2:0] c_DM_HALF  = 3'b001;
  localparam logic [2:0] c_DM_HALFU = 3'b010;
  localparam logic [2:0] c_DM_BYTE  = 3'b011;
  localparam logic [2:0] c_DM_BYTEU = 3'b100;

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_count;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [1:0]  r_off;
  logic [2:0]  r_dm;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_load;
  logic        w_timeout;

  // Request decode: alignment/legality check and store lane steering.
  always_comb begin
    w_bad   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata;
    case (bus.req_dmtype)
      c_DM_WORD: w_bad = |bus.req_addr[1:0];
      c_DM_HALF, c_DM_HALFU: begin
        w_bad   = bus.req_addr[0];
        w_wdata = {2{bus.req_wdata[15:0]}};
        if (bus.req_we) w_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      c_DM_BYTE, c_DM_BYTEU: begin
        w_wdata = {4{bus.req_wdata[7:0]}};
        if (bus.req_we) w_be = 4'b0001 << bus.req_addr[1:0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Load extraction from the returned word using the latched byte offset.
  always_comb begin
    w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_off)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    case (r_dm)
      c_DM_HALF:  w_load = {{16{w_half[15]}}, w_half};
      c_DM_HALFU: w_load = {16'h0000, w_half};
      c_DM_BYTE:  w_load = {{24{w_byte[7]}}, w_byte};
      c_DM_BYTEU: w_load = {24'h000000, w_byte};
      default:    w_load = bus.mem_rdata;
    endcase
  end

  assign w_timeout = (r_count >= c_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req_valid) w_next = w_bad ? S_RESP : S_ACCESS;
      S_ACCESS: if (bus.mem_ack || w_timeout) w_next = S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.stall      = bus.req_valid && ((r_state == S_IDLE) || (r_state == S_ACCESS));
    bus.mem_req    = (r_state == S_ACCESS);
    bus.resp_valid = (r_state == S_RESP);
  end

  // Bus fields are frozen for the whole access; the response is held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'h0;
      r_off       <= 2'd0;
      r_dm        <= 3'd0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (w_bad) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
            end else begin
              r_count     <= 8'd1;
              r_mem_we    <= bus.req_we;
              r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_be    <= w_be;
              r_off       <= bus.req_addr[1:0];
              r_dm        <= bus.req_dmtype;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            r_count <= 8'd0;
            r_err   <= 1'b0;
            r_rdata <= r_mem_we ? 32'h0 : w_load;
          end else if (w_timeout) begin
            r_count <= 8'd0;
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.resp_err  = r_err;
  assign bus.rdata_out = r_rdata;

endmodule

`default_nettype wire
